// File: rtl/gray_conv_arbiter.sv
// Round-robin shares one binary-to-Gray converter among NREQ requesters; the result is registered, valid the cycle after capture.
// Backpressure: while out_ready is low in FULL the result holds and no request is acked.
module gray_conv_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] bin,
  output logic [NREQ-1:0]   ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      gray,
  output logic [IDW-1:0]    out_id,
  output logic [7:0]        conv_cnt
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   gray_q, gray_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic [7:0]     conv_cnt_q, conv_cnt_d;

  logic [W-1:0]   ops [NREQ];
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;
  logic           any_req;
  logic           load_en;
  logic           load;
  logic [W-1:0]   sel_op;
  int             sum;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      ops[i] = bin[i*W +: W];
    end
  end

  // Scan from ptr upward, wrapping at NREQ so unused indices are never granted.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = 0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign any_req   = |req;
  assign load_en   = (state_q == IDLE) || out_ready;
  assign load      = load_en && any_req;
  assign sel_op    = ops[win];
  assign out_valid = (state_q == FULL);
  assign gray      = gray_q;
  assign out_id    = out_id_q;
  assign conv_cnt  = conv_cnt_q;

  always_comb begin
    ack = '0;
    if (load && !rst) ack[win] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gray_d     = gray_q;
    out_id_d   = out_id_q;
    conv_cnt_d = conv_cnt_q;
    if (out_valid && out_ready) conv_cnt_d = conv_cnt_q + 8'd1;
    if (load) begin
      gray_d   = sel_op ^ (sel_op >> 1);
      out_id_d = win;
      ptr_d    = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
    end
    case (state_q)
      IDLE:    if (any_req) state_d = FULL;
      FULL:    if (out_ready && !any_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gray_q     <= '0;
      out_id_q   <= '0;
      conv_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gray_q     <= gray_d;
      out_id_q   <= out_id_d;
      conv_cnt_q <= conv_cnt_d;
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: reset, single grant, round-robin, backpressure, exhaustive convert, counter wrap.
module tb_gray_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0001;
  logic [15:0] bin = 16'h000B;
  logic [3:0]  ack;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  gray;
  logic [1:0]  out_id;
  logic [7:0]  conv_cnt;

  int npass = 0;
  int ntotal = 0;
  int nfail = 0;

  logic [3:0] gtbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [3:0] rr_gray [4] = '{4'hE, 4'h7, 4'hA, 4'h2};
  logic [3:0] v4;

  gray_conv_arbiter #(.NREQ(4), .W(4), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bin       (bin),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gray      (gray),
    .out_id    (out_id),
    .conv_cnt  (conv_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state, with a request present: ack must stay low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_gray", 32'(gray), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_cnt", 32'(conv_cnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;

    // single request
    @(negedge clk);
    req = 4'b0001;
    out_ready = 1'b1;
    #1 chk("single_ack", 32'(ack), 32'h1);
    @(posedge clk);
    #1;
    chk("single_gray", 32'(gray), 32'hE);
    chk("single_id", 32'(out_id), 32'd0);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_cnt0", 32'(conv_cnt), 32'd0);
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_cnt", 32'(conv_cnt), 32'd1);

    // fill, then reset asynchronously mid-FULL
    @(negedge clk);
    bin = 16'h3C5B;
    req = 4'b0010;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("full_gray", 32'(gray), 32'h7);
    chk("full_id", 32'(out_id), 32'd1);
    chk("full_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    req = 4'b1111;
    #1 chk("hold_ack", 32'(ack), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_gray", 32'(gray), 32'd0);
    chk("arst_id", 32'(out_id), 32'd0);
    chk("arst_cnt", 32'(conv_cnt), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // round-robin with all requests held
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_ack", 32'(ack), 32'(4'b0001 << (k % 4)));
      @(posedge clk);
      #1;
      chk("rr_id", 32'(out_id), 32'(k % 4));
      chk("rr_gray", 32'(gray), 32'(rr_gray[k % 4]));
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_cnt", 32'(conv_cnt), 32'(k));
      @(negedge clk);
    end

    // backpressure: consumer stalls for five cycles
    req = 4'b0010;
    bin = 16'h3C9B;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ack", 32'(ack), 32'd0);
      @(posedge clk);
      #1;
      chk("bp_gray", 32'(gray), 32'hE);
      chk("bp_id", 32'(out_id), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_ack", 32'(ack), 32'h2);
    @(posedge clk);
    #1;
    chk("bp_rel_gray", 32'(gray), 32'hD);
    chk("bp_rel_id", 32'(out_id), 32'd1);
    chk("bp_rel_cnt", 32'(conv_cnt), 32'd5);

    // exhaustive conversion through requester 2, from a fresh reset
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b1;
    #1 rst = 1'b0;
    req = 4'b0100;
    for (int v = 0; v < 16; v++) begin
      v4 = 4'(v);
      bin = {4'h3, v4, 4'h5, 4'hB};
      #1 chk("ex_ack", 32'(ack), 32'h4);
      @(posedge clk);
      #1;
      chk("ex_gray", 32'(gray), 32'(gtbl[v]));
      chk("ex_id", 32'(out_id), 32'd2);
      @(negedge clk);
    end
    req = 4'b0000;
    #1 chk("ex_cnt15", 32'(conv_cnt), 32'd15);
    @(posedge clk);
    #1;
    chk("ex_cnt16", 32'(conv_cnt), 32'd16);
    chk("ex_idle", 32'(out_valid), 32'd0);

    // counter wrap after 256 accepted results
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    req = 4'b0001;
    repeat (256) @(posedge clk);
    #1 chk("wrap_cnt255", 32'(conv_cnt), 32'd255);
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk("wrap_cnt0", 32'(conv_cnt), 32'd0);
    chk("wrap_idle", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
